sipo_deserializer: RTL and testbench

//   Serial-in/parallel-out stage directly downstream of the reset D flip-flop.

---
 rtl/sipo_deserializer.sv | 103 ++++++++++
 tb/tb_sipo_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. Collects an MSB-first bit stream into
// WIDTH-bit words and presents them on a valid/ready port. The shift register
// keeps accepting bits while a word waits in the output register. A completed
// word that finds the output still occupied and unconsumed is dropped, and the
// sticky overrun flag is set.
module sipo_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Only WIDTH-1 bits are stored; the final bit of a word comes straight from din.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] word;

  assign accept   = din_valid & ~clear;
  assign complete = accept & (cnt_q == LastCnt);
  assign word     = {sh_q, din};

  // FSM next state and bit counter; clear takes priority over an incoming bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (accept) begin
      sh_d = word[WIDTH-2:0];
      if (complete) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StShift;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  // Output register, handshake and overrun detection.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q == StShift);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer (WIDTH=8): directed scenarios plus random traffic.
// An integer-level model predicts every edge. Words are queued when they enter the
// output register, and a separate monitor pops them on each handshake.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int unsigned m_acc;
  int          m_cnt;
  logic        m_valid;
  int unsigned m_dout;
  logic        m_ovr;
  logic [7:0]  exp_q[$];

  sipo_deserializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    if (m_valid) void'(exp_q.pop_back());
    m_acc   = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_dout  = 0;
    m_ovr   = 1'b0;
  endtask

  // Predict the effect of the coming rising edge.
  task automatic model_edge(input logic d, input logic v, input logic r, input logic c);
    bit done = 0;
    if (c) begin
      m_cnt = 0;
      m_acc = 0;
    end else if (v) begin
      m_acc = (m_acc * 2 + int'(d)) % 256;
      m_cnt++;
      if (m_cnt == 8) begin
        done  = 1;
        m_cnt = 0;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_dout  = m_acc;
        m_valid = 1'b1;
        exp_q.push_back(8'(m_acc));
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), m_dout);
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input logic d, input logic v, input logic r, input logic c);
    @(negedge clk);
    check_model();
    din        = d;
    din_valid  = v;
    dout_ready = r;
    clear      = c;
    model_edge(d, v, r, c);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [7:0] w, input logic r, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      step(w[i], 1'b1, r, 1'b0);
      if (gaps && i != 0) step(1'b0, 1'b0, r, 1'b0);
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from both clock edges.
  task automatic reset_pulse();
    @(posedge clk);
    #5;
    din_valid = 1'b0;
    clear     = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst dout", 32'(dout), 32'h0);
    chk("rst dout_valid", 32'(dout_valid), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst overrun", 32'(overrun), 32'h0);
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  // Monitor: just before each rising edge, a handshake consumes the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #8;
      if (!reset && dout_valid && dout_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL word: got unexpected %0h expected none", dout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            fails++;
            $display("FAIL word: got %0h expected %0h", dout, e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_acc = 0; m_cnt = 0; m_valid = 0; m_dout = 0; m_ovr = 0;
    // 1. Reset held while din toggles.
    reset = 1'b1; clear = 1'b0; din = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
    repeat (3) begin
      #6 din = ~din;
    end
    #1;
    chk("t1 dout", 32'(dout), 32'h0);
    chk("t1 dout_valid", 32'(dout_valid), 32'h0);
    chk("t1 busy", 32'(busy), 32'h0);
    chk("t1 overrun", 32'(overrun), 32'h0);
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // 2. Continuous word 0xB2 with ready high; valid lasts one cycle.
    send_word(8'hB2, 1'b1, 1'b0);
    after_edge();
    chk("t2 dout", 32'(dout), 32'hB2);
    chk("t2 dout_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("t2 valid one cycle", 32'(dout_valid), 32'h0);

    // 3. Same word with gaps between bits.
    send_word(8'hB2, 1'b1, 1'b1);
    after_edge();
    chk("t3 dout", 32'(dout), 32'hB2);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 4. Consumer stalled across two words: second word is dropped.
    send_word(8'hB2, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    after_edge();
    chk("t4 dout held", 32'(dout), 32'hB2);
    chk("t4 overrun", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("t4 drained", 32'(dout_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 5. Ready only on the edge completing the second word: no loss.
    reset_pulse();
    send_word(8'hB2, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h5A;
      step(w[i], 1'b1, (i == 0), 1'b0);
    end
    after_edge();
    chk("t5 dout", 32'(dout), 32'h5A);
    chk("t5 dout_valid", 32'(dout_valid), 32'h1);
    chk("t5 overrun", 32'(overrun), 32'h0);

    // 6a. Abort a partial word with an asynchronous reset.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    reset_pulse();
    send_word(8'h5A, 1'b0, 1'b0);
    after_edge();
    chk("t6 reset dout", 32'(dout), 32'h5A);
    // 6b. Abort a partial word with clear; the clear edge also presents a bit.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("t6 clear busy", 32'(busy), 32'h0);
    send_word(8'h5A, 1'b1, 1'b0);
    after_edge();
    chk("t6 clear dout", 32'(dout), 32'h5A);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(1)), ($urandom_range(9) < 7), 1'($urandom_range(1)),
           ($urandom_range(39) == 0));
    end

    // Drain and confirm every delivered word was seen.
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_model();
    chk("queue empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
